// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - decoded ALU with iterative shifter behind a valid/ready handshake
//
// Purpose:
//    Decodes aluop plus instruction bits {30,14,13,12} into an ALU command,
//    executes it on XLEN-bit operands and holds a registered result until the
//    consumer takes it. Shifts run SHIFT_STEP bits per cycle instead of using
//    a full barrel shifter.
//
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous, active-low reset
//    in_valid   operation offered            in_ready   operation accepted this cycle
//    aluop      00 ADD, 01 SUB, 10 R-type, 11 I-type
//    funct      {instr[30], instr[14:12]}
//    op_a       first operand                op_b       second operand / shamt
//    out_valid  result available             out_ready  consumer takes result
//    result     registered result            alucmd     command of the held result
//    illegal    unsupported decode (executed as ADD)

module alu_seq_unit #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      aluop,
   input  logic [3:0]      funct,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [3:0]      alucmd,
   output logic            illegal
);

   localparam int CW = $clog2(XLEN);
   // One extra bit so a step of XLEN bits is representable.
   localparam logic [CW:0] STEP = (CW+1)'(SHIFT_STEP);

   localparam logic [3:0] CMD_AND  = 4'b0000;
   localparam logic [3:0] CMD_OR   = 4'b0001;
   localparam logic [3:0] CMD_ADD  = 4'b0010;
   localparam logic [3:0] CMD_XOR  = 4'b0011;
   localparam logic [3:0] CMD_SLL  = 4'b0100;
   localparam logic [3:0] CMD_SRL  = 4'b0101;
   localparam logic [3:0] CMD_SUB  = 4'b0110;
   localparam logic [3:0] CMD_SRA  = 4'b0111;
   localparam logic [3:0] CMD_SLT  = 4'b1000;
   localparam logic [3:0] CMD_SLTU = 4'b1001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW:0]     count;
   logic [CW:0]     shamt;
   logic [CW:0]     step;
   logic            accept;
   logic [3:0]      dec_cmd;
   logic            dec_ill;
   logic            dec_shift;
   logic [XLEN-1:0] dec_res;
   logic [XLEN-1:0] shifted;

   assign shamt = {1'b0, op_b[CW-1:0]};

   // Command decode.
   always_comb begin
      dec_cmd = CMD_ADD;
      dec_ill = 1'b0;
      if (aluop == 2'b00) begin
         dec_cmd = CMD_ADD;
      end else if (aluop == 2'b01) begin
         dec_cmd = CMD_SUB;
      end else begin
         case (funct[2:0])
            3'b000:  dec_cmd = (aluop == 2'b10 && funct[3]) ? CMD_SUB : CMD_ADD;
            3'b001:  dec_cmd = CMD_SLL;
            3'b010:  dec_cmd = CMD_SLT;
            3'b011:  dec_cmd = CMD_SLTU;
            3'b100:  dec_cmd = CMD_XOR;
            3'b101:  dec_cmd = funct[3] ? CMD_SRA : CMD_SRL;
            3'b110:  dec_cmd = CMD_OR;
            default: dec_cmd = CMD_AND;
         endcase
         // instr[30] only has meaning for SRA, and for SUB in R-type.
         dec_ill = funct[3] && (funct[2:0] != 3'b101) &&
                   !(aluop == 2'b10 && funct[2:0] == 3'b000);
         if (dec_ill) begin
            dec_cmd = CMD_ADD;
         end
      end
   end

   assign dec_shift = (dec_cmd == CMD_SLL) || (dec_cmd == CMD_SRL) || (dec_cmd == CMD_SRA);

   // Single-cycle results; shifts start from op_a, which is also the
   // final answer when shamt is zero.
   always_comb begin
      dec_res = op_a + op_b;
      case (dec_cmd)
         CMD_AND:  dec_res = op_a & op_b;
         CMD_OR:   dec_res = op_a | op_b;
         CMD_XOR:  dec_res = op_a ^ op_b;
         CMD_SUB:  dec_res = op_a - op_b;
         CMD_SLT:  dec_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         CMD_SLTU: dec_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         CMD_SLL, CMD_SRL, CMD_SRA: dec_res = op_a;
         default:  dec_res = op_a + op_b;
      endcase
   end

   // Partial shifter: at most SHIFT_STEP positions per cycle.
   always_comb begin
      step = (count > STEP) ? STEP : count;
      case (alucmd)
         CMD_SLL: shifted = result << step;
         CMD_SRA: shifted = $signed(result) >>> step;
         default: shifted = result >> step;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
         end
         SHIFT: begin
            if (count <= STEP) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready && !in_valid) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      if (in_valid && in_ready) begin
         state_nx = (dec_shift && shamt != '0) ? SHIFT : DONE;
      end
   end

   assign accept = in_valid && in_ready;

   // The result register doubles as the shift working register; out_valid
   // stays low until the last step has landed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result  <= '0;
         alucmd  <= CMD_AND;
         illegal <= 1'b0;
         count   <= '0;
      end else if (accept) begin
         result  <= dec_res;
         alucmd  <= dec_cmd;
         illegal <= dec_ill;
         count   <= dec_shift ? shamt : '0;
      end else if (state == SHIFT) begin
         result  <= shifted;
         count   <= count - step;
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - self-checking bench for alu_seq_unit (SHIFT_STEP 1 and 4)

module tb_alu_seq_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, v4;
   logic        out_ready, or4;
   logic [1:0]  aluop;
   logic [3:0]  funct;
   logic [31:0] a, b;
   logic        rdy, rdy4, ov, ov4, ill, ill4;
   logic [31:0] res, res4;
   logic [3:0]  cmd, cmd4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy),
      .aluop(aluop), .funct(funct), .op_a(a), .op_b(b),
      .out_valid(ov), .out_ready(out_ready), .result(res),
      .alucmd(cmd), .illegal(ill));

   alu_seq_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4),
      .aluop(aluop), .funct(funct), .op_a(a), .op_b(b),
      .out_valid(ov4), .out_ready(or4), .result(res4),
      .alucmd(cmd4), .illegal(ill4));

   // Reference: decode table and plain arithmetic on the operands.
   function automatic void model(input logic [1:0] op, input logic [3:0] f,
                                 input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [3:0] c,
                                 output logic il);
      logic [2:0] f3;
      logic [4:0] sh;
      f3 = f[2:0];
      sh = y[4:0];
      il = f[3] && ((op == 2'b10 && f3 != 3'd0 && f3 != 3'd5) ||
                    (op == 2'b11 && f3 != 3'd5));
      if (op == 2'b00 || il)  c = 4'd2;
      else if (op == 2'b01)   c = 4'd6;
      else begin
         case (f3)
            3'd0:    c = (op == 2'b10 && f[3]) ? 4'd6 : 4'd2;
            3'd1:    c = 4'd4;
            3'd2:    c = 4'd8;
            3'd3:    c = 4'd9;
            3'd4:    c = 4'd3;
            3'd5:    c = f[3] ? 4'd7 : 4'd5;
            3'd6:    c = 4'd1;
            default: c = 4'd0;
         endcase
      end
      case (c)
         4'd0:    r = x & y;
         4'd1:    r = x | y;
         4'd2:    r = x + y;
         4'd3:    r = x ^ y;
         4'd4:    r = x << sh;
         4'd5:    r = x >> sh;
         4'd6:    r = x - y;
         4'd7:    r = $unsigned($signed(x) >>> sh);
         4'd8:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         default: r = (x < y) ? 32'd1 : 32'd0;
      endcase
   endfunction

   function automatic bit is_shift(input logic [3:0] c);
      return c == 4'd4 || c == 4'd5 || c == 4'd7;
   endfunction

   // Offer one op and return just after the accepting edge.
   task automatic send(input bit sel, input logic [1:0] op, input logic [3:0] f,
                       input logic [31:0] x, input logic [31:0] y);
      int n;
      @(negedge clk);
      aluop = op; funct = f; a = x; b = y;
      if (sel) v4 = 1'b1; else in_valid = 1'b1;
      n = 0;
      while (!(sel ? rdy4 : rdy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++; failures++;
         $display("FAIL send_timeout in_ready stayed 0 for %0d cycles", n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      v4 = 1'b0;
   endtask

   // Count cycles from accept until out_valid; no checking here.
   task automatic get_result(input bit sel, output int lat, output logic vld,
                             output logic [31:0] r, output logic [3:0] c, output logic il);
      lat = 1;
      @(negedge clk);
      while (!(sel ? ov4 : ov) && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      vld = sel ? ov4 : ov;
      r   = sel ? res4 : res;
      c   = sel ? cmd4 : cmd;
      il  = sel ? ill4 : ill;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #1;
      checks++;
      if (ov !== 1'b0 || ov4 !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid got=%b/%b want=0/0", ov, ov4);
      end
      checks++;
      if (res !== 32'd0 || cmd !== 4'd0 || ill !== 1'b0) begin
         failures++; $display("FAIL reset_regs got res=%h cmd=%h ill=%b want 0/0/0", res, cmd, ill);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (rdy !== 1'b1 || rdy4 !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready got=%b/%b want=1/1", rdy, rdy4);
      end
   endtask

   task automatic test_known_values;
      logic [3:0]  fn[8]  = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0011, 4'b1000, 4'b0111};
      logic [1:0]  ao[8]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
      logic [31:0] er[8]  = '{32'h12, 32'hC, 32'h3, 32'hF, 32'hC, 32'h0, 32'h12, 32'hC};
      logic [3:0]  ec[8]  = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd9, 4'd2, 4'd6};
      int lat; logic v, il; logic [31:0] r; logic [3:0] c;
      for (int i = 0; i < 8; i++) begin
         send(0, ao[i], fn[i], 32'h0000000F, 32'h00000003);
         get_result(0, lat, v, r, c, il);
         checks++;
         if (r !== er[i] || c !== ec[i] || il !== 1'b0 || lat != 1) begin
            failures++;
            $display("FAIL known_%0d got res=%h cmd=%h ill=%b lat=%0d want res=%h cmd=%h ill=0 lat=1",
                     i, r, c, il, lat, er[i], ec[i]);
         end
      end
      send(0, 2'b10, 4'b0010, 32'hFFFFFFFF, 32'd1);
      get_result(0, lat, v, r, c, il);
      checks++;
      if (r !== 32'd1 || c !== 4'd8) begin
         failures++; $display("FAIL slt_signed got res=%h cmd=%h want 1/8", r, c);
      end
      send(0, 2'b10, 4'b0011, 32'hFFFFFFFF, 32'd1);
      get_result(0, lat, v, r, c, il);
      checks++;
      if (r !== 32'd0 || c !== 4'd9) begin
         failures++; $display("FAIL sltu_unsigned got res=%h cmd=%h want 0/9", r, c);
      end
      send(0, 2'b10, 4'b1010, 32'hFFFFFFFF, 32'd1);
      get_result(0, lat, v, r, c, il);
      checks++;
      if (r !== 32'd0 || c !== 4'd2 || il !== 1'b1) begin
         failures++; $display("FAIL illegal_decode got res=%h cmd=%h ill=%b want 0/2/1", r, c, il);
      end
      send(0, 2'b10, 4'b1101, 32'h80000000, 32'd31);
      get_result(0, lat, v, r, c, il);
      checks++;
      if (r !== 32'hFFFFFFFF || c !== 4'd7 || lat != 32) begin
         failures++; $display("FAIL sra31 got res=%h cmd=%h lat=%0d want FFFFFFFF/7/32", r, c, lat);
      end
      send(0, 2'b11, 4'b0001, 32'h12345678, 32'd0);
      get_result(0, lat, v, r, c, il);
      checks++;
      if (r !== 32'h12345678 || lat != 1) begin
         failures++; $display("FAIL shamt0 got res=%h lat=%0d want 12345678/1", r, lat);
      end
   endtask

   task automatic test_random_ops;
      int lat, elat; logic v, il, eil; logic [31:0] r, er, x, y; logic [3:0] c, ec, f; logic [1:0] op;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3)); f = 4'($urandom_range(0, 15));
         x = $urandom; y = $urandom;
         model(op, f, x, y, er, ec, eil);
         elat = (is_shift(ec) && y[4:0] != 5'd0) ? 1 + int'(y[4:0]) : 1;
         send(0, op, f, x, y);
         get_result(0, lat, v, r, c, il);
         checks++;
         if (r !== er || c !== ec || il !== eil || lat != elat) begin
            failures++;
            $display("FAIL random_%0d op=%b f=%b a=%h b=%h got res=%h cmd=%h ill=%b lat=%0d want res=%h cmd=%h ill=%b lat=%0d",
                     i, op, f, x, y, r, c, il, lat, er, ec, eil, elat);
         end
      end
   endtask

   task automatic test_step4;
      int lat, elat; logic v, il, eil; logic [31:0] r, er, x, y; logic [3:0] c, ec, f;
      logic [3:0] sf[3] = '{4'b0001, 4'b0101, 4'b1101};
      send(1, 2'b11, 4'b0001, 32'd1, 32'd9);
      get_result(1, lat, v, r, c, il);
      checks++;
      if (r !== 32'h200 || c !== 4'd4 || lat != 4) begin
         failures++; $display("FAIL step4_sll9 got res=%h cmd=%h lat=%0d want 200/4/4", r, c, lat);
      end
      for (int i = 0; i < 12; i++) begin
         f = sf[$urandom_range(0, 2)];
         x = $urandom; y = $urandom;
         model(2'b10, f, x, y, er, ec, eil);
         elat = 1 + (int'(y[4:0]) + 3) / 4;
         send(1, 2'b10, f, x, y);
         get_result(1, lat, v, r, c, il);
         checks++;
         if (r !== er || c !== ec || lat != elat) begin
            failures++;
            $display("FAIL step4_rand_%0d f=%b a=%h b=%h got res=%h cmd=%h lat=%0d want res=%h cmd=%h lat=%0d",
                     i, f, x, y, r, c, lat, er, ec, elat);
         end
      end
   endtask

   task automatic test_reset_abort;
      int lat; logic v, il; logic [31:0] r; logic [3:0] c; bit seen;
      send(0, 2'b10, 4'b1101, 32'h80000000, 32'd31);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ov !== 1'b0 || res !== 32'd0 || cmd !== 4'd0) begin
         failures++; $display("FAIL reset_mid_shift got ov=%b res=%h cmd=%h want 0/0/0", ov, res, cmd);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (rdy !== 1'b1) begin
         failures++; $display("FAIL reset_release_ready got=%b want=1", rdy);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ov === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++; $display("FAIL reset_partial_result got out_valid=1 want none");
      end
      out_ready = 1'b0;
      send(0, 2'b00, 4'b0000, 32'h5, 32'h6);
      get_result(0, lat, v, r, c, il);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ov !== 1'b0 || res !== 32'd0) begin
         failures++; $display("FAIL reset_mid_done got ov=%b res=%h want 0/0", ov, res);
      end
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
   endtask

   task automatic test_back_to_back;
      int lat; logic v, il; logic [31:0] r; logic [3:0] c;
      logic [31:0] xs[8], ys[8];
      bit bad;
      out_ready = 1'b0;
      send(0, 2'b00, 4'b0000, 32'h11, 32'h22);
      get_result(0, lat, v, r, c, il);
      checks++;
      if (!v || r !== 32'h33) begin
         failures++; $display("FAIL bp_first got ov=%b res=%h want 1/33", v, r);
      end
      // Offered while stalled: must be ignored.
      aluop = 2'b01; a = 32'hDEAD; b = 32'h1; in_valid = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (ov !== 1'b1 || res !== 32'h33 || rdy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++; $display("FAIL bp_hold got ov=%b res=%h in_ready=%b want 1/33/0", ov, res, rdy);
      end
      for (int i = 0; i < 8; i++) begin
         xs[i] = $urandom; ys[i] = $urandom;
      end
      out_ready = 1'b1;
      aluop = 2'b00; a = xs[0]; b = ys[0];
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (ov !== 1'b1 || res !== xs[i] + ys[i]) begin
            failures++;
            $display("FAIL stream_%0d got ov=%b res=%h want 1/%h", i, ov, res, xs[i] + ys[i]);
         end
         if (i < 7) begin
            a = xs[i+1]; b = ys[i+1];
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      checks++;
      if (ov !== 1'b0) begin
         failures++; $display("FAIL stream_drain got ov=%b want 0", ov);
      end
   endtask

   initial begin
      in_valid = 1'b0; v4 = 1'b0; out_ready = 1'b1; or4 = 1'b1;
      aluop = 2'b00; funct = 4'd0; a = 32'd0; b = 32'd0;
      test_reset;
      test_known_values;
      test_random_ops;
      test_step4;
      test_reset_abort;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised successor to the combinational ALU control decode. It decodes `aluop` plus instruction bits {30,14,13,12}, executes the resulting operation on XLEN-bit operands, and returns a registered result over a valid/ready handshake. Shifts are iterative, at SHIFT_STEP bits per cycle, so a wide barrel shifter is not needed. It sits between the register-file read stage and writeback, and replaces the separate control decode plus ALU pair.

## Interface
- XLEN, 32, operand/result width; power of 2, ≥ 8
- SHIFT_STEP, 1, maximum bits shifted per cycle; power of 2, 1..XLEN
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept an operation this cycle
- aluop  in  2  00 = ADD (load/store), 01 = SUB (branch), 10 = R-type, 11 = I-type
- funct  in  4  {instr[30], instr[14:12]}
- op_a  in  XLEN  first operand
- op_b  in  XLEN  second operand (register or immediate); shamt = op_b[log2(XLEN)-1:0]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- alucmd  out  4  decoded command for the held result
- illegal  out  1  decode was unsupported; result is ADD

## Operation
- Command encoding:
  - AND = 0000, OR = 0001, ADD = 0010, XOR = 0011
  - SLL = 0100, SRL = 0101, SUB = 0110, SRA = 0111
  - SLT = 1000, SLTU = 1001
- Decode by `aluop`:
  - 00 → ADD; 01 → SUB.
  - 10 → funct3 000 gives ADD, or SUB when funct[3]=1. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, or SRA when funct[3]=1, 110 OR, 111 AND.
  - 11 → same table, but funct3 000 is always ADD (funct[3] ignored).
- Illegal decode: funct[3]=1 with funct3 ∉ {000, 101} when aluop=10, or funct[3]=1 with funct3 ≠ 101 when aluop=11. Response: alucmd=ADD, illegal=1, result = op_a + op_b.
- Arithmetic:
  - ADD and SUB wrap modulo 2^XLEN.
  - SLT is a signed compare, SLTU unsigned; result is zero-extended 0 or 1.
  - SRA replicates op_a[XLEN-1].
- States:
  - IDLE: in_ready=1.
  - SHIFT: a shift is in progress; in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Transitions:
  - Accept (in_valid & in_ready) of a non-shift op, or of a shift with shamt=0 → DONE.
  - Accept of a shift with shamt>0 → SHIFT, with the remaining count set to shamt.
  - SHIFT: each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining. When remaining reaches 0 → DONE.
  - DONE & out_ready & !in_valid → IDLE.
  - DONE & out_ready & in_valid → accept the new op (same rules as IDLE).
- Operands are captured at accept; input changes after accept have no effect.
- result, alucmd and illegal stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst low, asynchronous): state=IDLE, out_valid=0, result=0, alucmd=0000, illegal=0, shift count=0. in_ready=1 once rst deasserts.
- Non-shift latency: out_valid is high in the cycle after accept.
- Shift latency: 1 + ceil(shamt/SHIFT_STEP) cycles from accept to out_valid.
- Throughput: one non-shift op per cycle when out_ready is held high.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation; no partial result is ever presented.
- in_valid while in_ready=0 is ignored; the source must hold the op until it is accepted.

## Test plan
- Reset check: assert rst mid-SHIFT → out_valid=0, result=0, alucmd=0000 immediately; after release, in_ready=1.
- Decode sweep (aluop=10): op_a=0x0000000F, op_b=0x00000003 across every funct → ADD 0x12, SUB 0xC, AND 0x3, OR 0xF, XOR 0xC, SLTU 0. aluop=00 and 01 give ADD/SUB regardless of funct.
- Signed vs unsigned compare: op_a=0xFFFFFFFF, op_b=1 → SLT=1, SLTU=0. funct=1_010, aluop=10 → illegal=1, result=0x00000000.
- Shift timing (SHIFT_STEP=1): SRA with op_a=0x80000000, shamt=31 → result=0xFFFFFFFF, out_valid 32 cycles after accept. shamt=0 → result=op_a after 1 cycle.
- SHIFT_STEP=4: SLL with op_a=1, shamt=9 → result=0x200 after 4 cycles.
- Back-pressure and streaming: hold out_ready=0 for 5 cycles → result stable, in_ready=0. Then stream 8 ADDs with out_ready=1 → one result per cycle, in order.
